oai_response_checker: RTL

Clocked response checker for the OAI22 cell characterisation bench. It consumes the exhaustive 4-input vector sequence applied to the cell (a,b,c,d) and the cell output y. For each vector it verifies both the vector order and the output against the golden OAI22 function, y = ~((a|b)&(c|d)). It reports a pass/fail summary when the sweep completes, and sits beside the stimulus source and the DUT in the cell bench.

---
 rtl/oai_chk_pkg.sv | 21 ++
 rtl/oai_response_checker_if.sv | 32 +++
 rtl/oai22_golden.sv | 14 +
 rtl/oai_response_checker.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/oai_chk_pkg.sv
// Shared types and constants for the OAI22 response checker.
//   state_t     : checker FSM states
//   NUM_VECTORS : vectors per exhaustive sweep of a 4-input cell
//   SEQ_ERR/OUT_ERR : bit positions inside first_err_kind
package oai_chk_pkg;

  localparam int unsigned NUM_VECTORS = 16;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned ERR_W       = 5;
  localparam int unsigned KIND_W      = 2;

  localparam int unsigned SEQ_ERR = 1;
  localparam int unsigned OUT_ERR = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/oai_response_checker_if.sv
// Bench-side bus of the OAI22 response checker.
//   start, a..d, y : stimulus/response observed by the checker
//   busy, done, pass, err_count, first_err_* : sweep result
// master = stimulus/bench side, slave = checker side.
interface oai_response_checker_if;
  import oai_chk_pkg::*;

  logic              start;
  logic              a;
  logic              b;
  logic              c;
  logic              d;
  logic              y;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic              first_err_valid;
  logic [IDX_W-1:0]  first_err_idx;
  logic [KIND_W-1:0] first_err_kind;

  modport master (
    output start, a, b, c, d, y,
    input  busy, done, pass, err_count, first_err_valid, first_err_idx, first_err_kind
  );

  modport slave (
    input  start, a, b, c, d, y,
    output busy, done, pass, err_count, first_err_valid, first_err_idx, first_err_kind
  );

endinterface

// File: rtl/oai22_golden.sv
// Golden OAI22 function: y = ~((a|b)&(c|d)). Purely combinational.
//   a, b, c, d : cell inputs
//   y          : expected cell output
module oai22_golden (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y
);

  assign y = ~((a | b) & (c | d));

endmodule

// File: rtl/oai_response_checker.sv
// Response checker for an exhaustive OAI22 characterisation sweep.
// Each vector is held HOLD_CYCLES cycles; the applied vector and y are
// sampled SETTLE_CYCLES into each window and checked against the expected
// index and the golden function. Results are held until the next start.
//   clk, rst : clock, synchronous active-high reset
//   bus      : stimulus/response inputs and registered result outputs
module oai_response_checker
  import oai_chk_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  oai_response_checker_if.slave bus
);

  localparam int unsigned CYC_W = $clog2(HOLD_CYCLES);

  state_t             state_q;
  state_t             state_d;
  logic [CYC_W-1:0]   cyc_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ERR_W-1:0]   err_q;
  logic [ERR_W-1:0]   err_d;
  logic               fev_q;
  logic [IDX_W-1:0]   fidx_q;
  logic [KIND_W-1:0]  fkind_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;

  logic               clear_c;
  logic               run_c;
  logic               sample_c;
  logic               wrap_c;
  logic               last_c;
  logic               seq_err_c;
  logic               out_err_c;
  logic               hit_c;
  logic               golden_y;
  logic [IDX_W-1:0]   vec_c;
  logic [KIND_W-1:0]  kind_c;

  oai22_golden u_golden (
    .a (bus.a),
    .b (bus.b),
    .c (bus.c),
    .d (bus.d),
    .y (golden_y)
  );

  // Window timing and per-vector error detection
  assign vec_c     = {bus.a, bus.b, bus.c, bus.d};
  assign sample_c  = run_c && (cyc_q == CYC_W'(SETTLE_CYCLES));
  assign wrap_c    = run_c && (cyc_q == CYC_W'(HOLD_CYCLES - 1));
  assign last_c    = wrap_c && (idx_q == IDX_W'(NUM_VECTORS - 1));
  assign seq_err_c = (vec_c != idx_q);
  assign out_err_c = (bus.y != golden_y);
  assign hit_c     = sample_c && (seq_err_c || out_err_c);
  // Includes the current sample so the final vector is counted when done rises
  assign err_d     = err_q + ERR_W'(hit_c);

  always_comb begin
    kind_c          = '0;
    kind_c[SEQ_ERR] = seq_err_c;
    kind_c[OUT_ERR] = out_err_c;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start during RUN is ignored
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_c)    state_d = DONE;
      DONE:    if (bus.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // FSM control decode
  always_comb begin
    clear_c = 1'b0;
    run_c   = 1'b0;
    unique case (state_q)
      IDLE, DONE: clear_c = bus.start;
      RUN:        run_c   = 1'b1;
      default:    ;
    endcase
  end

  // Sweep counters and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fidx_q  <= '0;
      fkind_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (clear_c) begin
      cyc_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fidx_q  <= '0;
      fkind_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (run_c) begin
      cyc_q <= wrap_c ? '0 : cyc_q + CYC_W'(1);
      if (wrap_c) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (hit_c) begin
        err_q <= err_d;
        if (!fev_q) begin
          fev_q   <= 1'b1;
          fidx_q  <= idx_q;
          fkind_q <= kind_c;
        end
      end
      if (last_c) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        pass_q <= (err_d == '0);
      end
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_idx   = fidx_q;
  assign bus.first_err_kind  = fkind_q;

endmodule
